// File: rtl/axils_regfile.sv
// AXI4-Lite slave terminating into NUM_REGS 32-bit registers with per-register write pulses.
// Build macro AXILS_WSTRB_EN enables byte-strobe writes; without it every write updates the full word.
module axils_regfile #(
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [31:0]            AWADDR,
    input  logic [2:0]             AWPROT,
    input  logic                   AWVALID,
    output logic                   AWREADY,
    input  logic [31:0]            WDATA,
    input  logic [3:0]             WSTRB,
    input  logic                   WVALID,
    output logic                   WREADY,
    output logic                   BVALID,
    input  logic                   BREADY,
    output logic [1:0]             BRESP,
    input  logic [31:0]            ARADDR,
    input  logic [2:0]             ARPROT,
    input  logic                   ARVALID,
    output logic                   ARREADY,
    output logic [31:0]            RDATA,
    output logic [1:0]             RRESP,
    output logic                   RVALID,
    input  logic                   RREADY,
    output logic [32*NUM_REGS-1:0] reg_q,
    output logic [NUM_REGS-1:0]    wr_pulse
);

    localparam int         IDXW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef struct packed {
        logic            hit;
        logic [IDXW-1:0] idx;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] addr);
        logic [31:0] word;
        dec_t        d;
        word  = (addr - BASE_ADDR) >> 2;
        d.hit = (addr >= BASE_ADDR) && (word < 32'(NUM_REGS));
        d.idx = word[IDXW-1:0];
        return d;
    endfunction

    logic                         awready_q, awready_d;
    logic                         wready_q,  wready_d;
    logic                         aw_held_q, aw_held_d;
    logic [31:0]                  aw_addr_q, aw_addr_d;
    logic                         w_held_q,  w_held_d;
    logic [31:0]                  wdata_q,   wdata_d;
    logic [3:0]                   wstrb_q,   wstrb_d;
    logic                         bvalid_q,  bvalid_d;
    logic [1:0]                   bresp_q,   bresp_d;
    logic                         arready_q, arready_d;
    logic                         rvalid_q,  rvalid_d;
    logic [31:0]                  rdata_q,   rdata_d;
    logic [1:0]                   rresp_q,   rresp_d;
    logic [NUM_REGS-1:0][31:0]    regs_q,    regs_d;
    logic [NUM_REGS-1:0]          wr_pulse_q, wr_pulse_d;

    logic        aw_hs, w_hs, commit;
    logic [31:0] cm_data, byte_mask;
    logic [3:0]  cm_strb;
    dec_t        cm_dec, ar_dec;

    assign aw_hs   = AWVALID && awready_q;
    assign w_hs    = WVALID && wready_q;
    // A commit needs both halves, each either already held or handshaking on this edge.
    assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign cm_dec  = decode(aw_held_q ? aw_addr_q : AWADDR);
    assign cm_data = w_held_q ? wdata_q : WDATA;
    assign ar_dec  = decode(ARADDR);

`ifdef AXILS_WSTRB_EN
    assign cm_strb = w_held_q ? wstrb_q : WSTRB;
`else
    logic unused_strb;
    assign unused_strb = ^wstrb_q;
    assign cm_strb     = 4'hF;
`endif

    assign byte_mask = {{8{cm_strb[3]}}, {8{cm_strb[2]}}, {8{cm_strb[1]}}, {8{cm_strb[0]}}};

    always_comb begin
        // NOTE: every next-state signal is defaulted first so no path through this block infers a latch.
        aw_held_d  = aw_held_q;
        aw_addr_d  = aw_addr_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;

        if (bvalid_q && BREADY) begin
            bvalid_d = 1'b0;
        end

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = cm_dec.hit ? OKAY : SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (cm_dec.hit && (cm_dec.idx == IDXW'(i))) begin
                    regs_d[i]     = (regs_q[i] & ~byte_mask) | (cm_data & byte_mask);
                    wr_pulse_d[i] = 1'b1;
                end
            end
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_addr_d = AWADDR;
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = WDATA;
                wstrb_d  = WSTRB;
            end
        end

        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;

        if (rvalid_q && RREADY) begin
            rvalid_d = 1'b0;
        end

        // Reads sample regs_q, so a same-edge write commit is not yet visible here.
        if (ARVALID && arready_q) begin
            rvalid_d = 1'b1;
            rresp_d  = ar_dec.hit ? OKAY : SLVERR;
            rdata_d  = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ar_dec.hit && (ar_dec.idx == IDXW'(i))) begin
                    rdata_d = regs_q[i];
                end
            end
        end

        arready_d = !rvalid_d;
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_held_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
            // NOTE: the register array is reset because its reset value is visible on reg_q.
            regs_q     <= {NUM_REGS{RESET_VAL}};
            wr_pulse_q <= '0;
        end else begin
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            aw_held_q  <= aw_held_d;
            aw_addr_q  <= aw_addr_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign AWREADY  = awready_q;
    assign WREADY   = wready_q;
    assign BVALID   = bvalid_q;
    assign BRESP    = bresp_q;
    assign ARREADY  = arready_q;
    assign RVALID   = rvalid_q;
    assign RDATA    = rdata_q;
    assign RRESP    = rresp_q;
    assign reg_q    = regs_q;
    assign wr_pulse = wr_pulse_q;

    logic unused_prot;
    assign unused_prot = ^{AWPROT, ARPROT};

endmodule

// File: tb/tb_axils_regfile.sv
// Self-checking bench for axils_regfile: directed cases plus randomized traffic against an array model.
// Honours AXILS_WSTRB_EN the same way the design does.
module tb_axils_regfile;

    localparam int          NR   = 8;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [31:0] RV   = 32'hCAFE_0001;

`ifdef AXILS_WSTRB_EN
    localparam logic [31:0] STRB_EXP = 32'h11BB_33DD;
`else
    localparam logic [31:0] STRB_EXP = 32'hAABB_CCDD;
`endif

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic [31:0]     AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]      AWPROT, ARPROT;
    logic            AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic            ARVALID, ARREADY, RVALID, RREADY;
    logic [3:0]      WSTRB;
    logic [1:0]      BRESP, RRESP;
    logic [32*NR-1:0] reg_q;
    logic [NR-1:0]   wr_pulse;

    always #5 ACLK = ~ACLK;

    axils_regfile #(.NUM_REGS(NR), .BASE_ADDR(BASE), .RESET_VAL(RV)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_q(reg_q), .wr_pulse(wr_pulse)
    );

    logic [31:0] model [NR];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) / 4) < NR);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [255:0] model_vec();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[32*i +: 32] = model[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model[i] = RV;
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [3:0] en;
`ifdef AXILS_WSTRB_EN
        en = s;
`else
        en = 4'hF;
`endif
        if (in_range(a)) begin
            for (int k = 0; k < 4; k++)
                if (en[k]) model[widx(a)][8*k +: 8] = d[8*k +: 8];
        end
    endtask

    task automatic send_aw(input logic [31:0] addr, input int delay);
        int t;
        repeat (delay) @(negedge ACLK);
        AWADDR = addr; AWPROT = 3'($urandom); AWVALID = 1'b1;
        t = 0;
        while (!AWREADY && t < 50) begin @(negedge ACLK); t++; end
        if (!AWREADY) check("aw_timeout", AWREADY, 1'b1);
        @(posedge ACLK);
        @(negedge ACLK);
        AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int delay);
        int t;
        repeat (delay) @(negedge ACLK);
        WDATA = data; WSTRB = strb; WVALID = 1'b1;
        t = 0;
        while (!WREADY && t < 50) begin @(negedge ACLK); t++; end
        if (!WREADY) check("w_timeout", WREADY, 1'b1);
        @(posedge ACLK);
        @(negedge ACLK);
        WVALID = 1'b0;
    endtask

    // Called on a negedge; returns on the negedge after the B handshake.
    task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_hold);
        logic [1:0]    exp_resp;
        logic [NR-1:0] exp_pulse;
        exp_resp  = in_range(addr) ? 2'b00 : 2'b10;
        exp_pulse = '0;
        if (in_range(addr)) exp_pulse[widx(addr)] = 1'b1;
        fork
            send_aw(addr, aw_dly);
            send_w(data, strb, w_dly);
        join
        model_write(addr, data, strb);
        check("b_valid", BVALID, 1'b1);
        check("b_resp", BRESP, exp_resp);
        check("wr_pulse", wr_pulse, exp_pulse);
        check("reg_q_after_write", reg_q, model_vec());
        for (int k = 0; k < b_hold; k++) begin
            @(negedge ACLK);
            check("b_valid_hold", BVALID, 1'b1);
            check("b_resp_hold", BRESP, exp_resp);
            check("aw_ready_blocked", AWREADY, 1'b0);
            check("w_ready_blocked", WREADY, 1'b0);
            check("wr_pulse_one_cycle", wr_pulse, '0);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        check("b_valid_clear", BVALID, 1'b0);
        check("aw_ready_back", AWREADY, 1'b1);
        check("w_ready_back", WREADY, 1'b1);
        if (b_hold == 0) check("wr_pulse_one_cycle", wr_pulse, '0);
    endtask

    // Called on a negedge; expected data is taken from the model as it stands at the AR edge.
    task automatic read_txn(input logic [31:0] addr, input int r_hold);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int t;
        exp_data = 32'h0;
        exp_resp = 2'b10;
        if (in_range(addr)) begin
            exp_data = model[widx(addr)];
            exp_resp = 2'b00;
        end
        ARADDR = addr; ARPROT = 3'($urandom); ARVALID = 1'b1;
        t = 0;
        while (!ARREADY && t < 50) begin @(negedge ACLK); t++; end
        if (!ARREADY) check("ar_timeout", ARREADY, 1'b1);
        @(posedge ACLK);
        @(negedge ACLK);
        ARVALID = 1'b0;
        check("r_valid", RVALID, 1'b1);
        check("r_data", RDATA, exp_data);
        check("r_resp", RRESP, exp_resp);
        check("ar_ready_low", ARREADY, 1'b0);
        for (int k = 0; k < r_hold; k++) begin
            @(negedge ACLK);
            check("r_valid_hold", RVALID, 1'b1);
            check("r_data_hold", RDATA, exp_data);
            check("r_resp_hold", RRESP, exp_resp);
        end
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
        check("r_valid_clear", RVALID, 1'b0);
        check("ar_ready_back", ARREADY, 1'b1);
    endtask

    task automatic check_reset_state();
        check("rst_awready", AWREADY, 1'b0);
        check("rst_wready", WREADY, 1'b0);
        check("rst_arready", ARREADY, 1'b0);
        check("rst_bvalid", BVALID, 1'b0);
        check("rst_rvalid", RVALID, 1'b0);
        check("rst_bresp", BRESP, 2'b00);
        check("rst_rresp", RRESP, 2'b00);
        check("rst_rdata", RDATA, 32'h0);
        check("rst_wr_pulse", wr_pulse, '0);
        check("rst_reg_q", reg_q, model_vec());
    endtask

    task automatic release_reset();
        ARESET = 1'b0;
        @(negedge ACLK);
        check("ready_aw_after_rst", AWREADY, 1'b1);
        check("ready_w_after_rst", WREADY, 1'b1);
        check("ready_ar_after_rst", ARREADY, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        ARESET = 1'b1;
        AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
        model_reset();
        repeat (3) @(negedge ACLK);
        check_reset_state();
        release_reset();

        // Same-cycle AW+W, immediate BREADY, then read back.
        write_txn(BASE + 32'h08, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        check("reg2_value", reg_q[95:64], 32'hDEAD_BEEF);
        read_txn(BASE + 32'h08, 0);

        // W leads AW by 3 cycles, B held off 4 cycles.
        write_txn(BASE + 32'h10, 32'h0BAD_F00D, 4'hF, 3, 0, 4);
        // AW leads W.
        write_txn(BASE + 32'h1C, 32'h1357_9BDF, 4'hF, 0, 2, 1);

        // Out of range write and read.
        write_txn(BASE + 32'h20, 32'h1234_5678, 4'hF, 0, 0, 1);
        read_txn(BASE + 32'h20, 2);
        write_txn(BASE - 32'h04, 32'h8765_4321, 4'hF, 1, 0, 0);

        // Byte strobes.
        write_txn(BASE + 32'h04, 32'h1122_3344, 4'hF, 0, 0, 0);
        write_txn(BASE + 32'h04, 32'hAABB_CCDD, 4'b0101, 0, 0, 0);
        check("strb_reg1", reg_q[63:32], STRB_EXP);
        write_txn(BASE + 32'h04, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0);

        // Read and write commit to reg3 on the same edge: read returns the old value.
        write_txn(BASE + 32'h0C, 32'h0000_0001, 4'hF, 0, 0, 0);
        fork
            write_txn(BASE + 32'h0C, 32'h0000_0002, 4'hF, 0, 0, 0);
            read_txn(BASE + 32'h0C, 0);
        join
        read_txn(BASE + 32'h0C, 0);

        // Reset while BVALID is pending.
        fork
            send_aw(BASE + 32'h18, 0);
            send_w(32'h5555_AAAA, 4'hF, 0);
        join
        check("bvalid_before_rst", BVALID, 1'b1);
        ARESET = 1'b1;
        model_reset();
        @(negedge ACLK);
        check_reset_state();
        release_reset();

        // A held AW must be discarded by reset and not pair with a later W.
        send_aw(BASE + 32'h14, 0);
        check("aw_held_blocks", AWREADY, 1'b0);
        ARESET = 1'b1;
        @(negedge ACLK);
        check_reset_state();
        release_reset();
        write_txn(BASE + 32'h00, 32'h600D_CAFE, 4'hF, 2, 0, 0);

        // Randomized traffic, including addresses below and above the register window.
        for (int n = 0; n < 40; n++) begin
            a = BASE - 32'd16 + (32'($urandom_range(0, 14)) << 2) + 32'($urandom_range(0, 3));
            write_txn(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 2));
            a = BASE - 32'd16 + (32'($urandom_range(0, 14)) << 2) + 32'($urandom_range(0, 3));
            read_txn(a, $urandom_range(0, 2));
        end
        check("final_reg_q", reg_q, model_vec());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
